// File: rtl/aidc_lite_blk_buf.sv
// aidc_lite_blk_buf
//   Block staging buffer between the AIDC-Lite engine's AHB read path and the
//   compressor core. It captures WORDS_PER_BLK words per block from the engine
//   write strobe and replays each complete block as an in-order read stream.
//
//   Optional feature macro: AIDC_LITE_BLK_BUF_PINGPONG_EN
//     defined   -> two banks (ping-pong), free_banks_o ranges 0..2
//     undefined -> bank 0 only, free_banks_o ranges 0..1 (MSB tied to 0)
//
// Ports
//   clk          clock, rising edge
//   rst_n        asynchronous active-low reset
//   clear_i      synchronous flush; wins over wren_i/rden_i in the same cycle
//   wren_i       write strobe (engine buf_wren_o)
//   wdata_i      write data   (engine buf_wdata_o)
//   blk_valid_o  a complete block is readable (level)
//   rden_i       read strobe, one word per cycle
//   rdata_o      registered read data, held until the next accepted read
//   rlast_o      rdata_o is the final word of its block
//   free_banks_o number of banks able to accept writes
//   ovf_o        sticky: a write was dropped
//   udf_o        sticky: a read was issued while blk_valid_o was low
module aidc_lite_blk_buf #(
  parameter int unsigned WORDS_PER_BLK = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear_i,
  input  logic        wren_i,
  input  logic [31:0] wdata_i,
  output logic        blk_valid_o,
  input  logic        rden_i,
  output logic [31:0] rdata_o,
  output logic        rlast_o,
  output logic [1:0]  free_banks_o,
  output logic        ovf_o,
  output logic        udf_o
);

  localparam int unsigned AW = $clog2(WORDS_PER_BLK);
  localparam logic [AW-1:0] LAST = AW'(WORDS_PER_BLK - 1);
`ifdef AIDC_LITE_BLK_BUF_PINGPONG_EN
  localparam int unsigned NB = 2;
`else
  localparam int unsigned NB = 1;
`endif
  localparam int unsigned DEPTH = NB * WORDS_PER_BLK;
  localparam int unsigned MW    = $clog2(DEPTH);

  logic [31:0]    mem [DEPTH];
  logic [NB-1:0]  full_q, full_d;
  logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [MW-1:0]  wr_addr, rd_addr;
  logic           wr_full, rd_full;
  logic           wr_acc, rd_acc, wr_done, rd_done;

`ifdef AIDC_LITE_BLK_BUF_PINGPONG_EN
  logic wr_bank_q, rd_bank_q;

  assign wr_full      = full_q[wr_bank_q];
  assign rd_full      = full_q[rd_bank_q];
  assign wr_addr      = {wr_bank_q, wr_ptr_q};
  assign rd_addr      = {rd_bank_q, rd_ptr_q};
  assign free_banks_o = {1'b0, ~full_q[0]} + {1'b0, ~full_q[1]};

  // A bank is never both filling and full, so the set and clear below always
  // target different flags and both take effect on the same edge.
  always_comb begin
    full_d = full_q;
    if (wr_done) full_d[wr_bank_q] = 1'b1;
    if (rd_done) full_d[rd_bank_q] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
    end else if (clear_i) begin
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
    end else begin
      if (wr_done) wr_bank_q <= ~wr_bank_q;
      if (rd_done) rd_bank_q <= ~rd_bank_q;
    end
  end
`else
  assign wr_full      = full_q[0];
  assign rd_full      = full_q[0];
  assign wr_addr      = wr_ptr_q;
  assign rd_addr      = rd_ptr_q;
  assign free_banks_o = {1'b0, ~full_q[0]};

  // Single bank: completing a write needs the bank empty, completing a read
  // needs it full, so at most one of these fires per cycle.
  always_comb begin
    full_d = full_q;
    if (wr_done) full_d[0] = 1'b1;
    if (rd_done) full_d[0] = 1'b0;
  end
`endif

  assign blk_valid_o = rd_full;

  assign wr_acc  = wren_i & ~wr_full & ~clear_i;
  assign rd_acc  = rden_i &  rd_full & ~clear_i;
  assign wr_done = wr_acc & (wr_ptr_q == LAST);
  assign rd_done = rd_acc & (rd_ptr_q == LAST);

  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_addr] <= wdata_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      rdata_o  <= '0;
      rlast_o  <= 1'b0;
      ovf_o    <= 1'b0;
      udf_o    <= 1'b0;
    end else if (clear_i) begin
      // rdata_o deliberately holds across a flush.
      full_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      rlast_o  <= 1'b0;
      ovf_o    <= 1'b0;
      udf_o    <= 1'b0;
    end else begin
      full_q <= full_d;
      // Power-of-two block size: the pointers wrap to 0 naturally.
      if (wr_acc) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (wren_i && wr_full) ovf_o <= 1'b1;
      if (rd_acc) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        rdata_o  <= mem[rd_addr];
        rlast_o  <= rd_done;
      end else if (rden_i) begin
        rlast_o  <= 1'b0;
        udf_o    <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_aidc_lite_blk_buf.sv
module tb_aidc_lite_blk_buf;

  localparam int unsigned W = 32;
`ifdef AIDC_LITE_BLK_BUF_PINGPONG_EN
  localparam logic [1:0] FREE_ALL = 2'd2;
`else
  localparam logic [1:0] FREE_ALL = 2'd1;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear_i = 1'b0;
  logic        wren_i = 1'b0;
  logic [31:0] wdata_i = '0;
  logic        rden_i = 1'b0;
  logic        blk_valid_o;
  logic [31:0] rdata_o;
  logic        rlast_o;
  logic [1:0]  free_banks_o;
  logic        ovf_o;
  logic        udf_o;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  logic [32:0] exp_q[$];

  aidc_lite_blk_buf #(.WORDS_PER_BLK(W)) dut (
    .clk(clk), .rst_n(rst_n), .clear_i(clear_i), .wren_i(wren_i),
    .wdata_i(wdata_i), .blk_valid_o(blk_valid_o), .rden_i(rden_i),
    .rdata_o(rdata_o), .rlast_o(rlast_o), .free_banks_o(free_banks_o),
    .ovf_o(ovf_o), .udf_o(udf_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: any read accepted on an edge must match the head of the queue.
  initial begin
    logic        fire;
    logic [32:0] e;
    forever begin
      @(posedge clk);
      fire = rst_n && rden_i && !clear_i && blk_valid_o;
      #1;
      if (fire) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_read", rdata_o, 32'hxxxx_xxxx);
        end else begin
          e = exp_q.pop_front();
          chk("rdata", rdata_o, e[31:0]);
          chk("rlast", {31'd0, rlast_o}, {31'd0, e[32]});
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input logic clr, input logic wr, input logic [31:0] wd, input logic rd);
    clear_i = clr; wren_i = wr; wdata_i = wd; rden_i = rd;
    @(posedge clk); #1;
    clear_i = 1'b0; wren_i = 1'b0; rden_i = 1'b0;
  endtask

  task automatic wr_blk(input logic [31:0] base);
    for (int i = 0; i < W; i++) cyc(1'b0, 1'b1, base + 32'(i), 1'b0);
  endtask

  task automatic rd_blk(input logic [31:0] base);
    for (int i = 0; i < W; i++) begin
      exp_q.push_back({(i == W - 1), base + 32'(i)});
      cyc(1'b0, 1'b0, '0, 1'b1);
    end
  endtask

  task automatic wr_rd_blk(input logic [31:0] wbase, input logic [31:0] rbase);
    for (int i = 0; i < W; i++) begin
      exp_q.push_back({(i == W - 1), rbase + 32'(i)});
      cyc(1'b0, 1'b1, wbase + 32'(i), 1'b1);
    end
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_blk_valid", {31'd0, blk_valid_o}, 32'd0);
    chk("rst_rdata", rdata_o, 32'd0);
    chk("rst_ovf_udf", {30'd0, ovf_o, udf_o}, 32'd0);
    chk("rst_free", {30'd0, free_banks_o}, {30'd0, FREE_ALL});
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Basic block: valid rises after the edge capturing the last word
    for (int i = 0; i < W - 1; i++) cyc(1'b0, 1'b1, 32'h1000_0000 + 32'(i), 1'b0);
    chk("valid_before_last", {31'd0, blk_valid_o}, 32'd0);
    cyc(1'b0, 1'b1, 32'h1000_001F, 1'b0);
    chk("valid_after_last", {31'd0, blk_valid_o}, 32'd1);
    chk("free_after_fill", {30'd0, free_banks_o}, {30'd0, FREE_ALL - 2'd1});
    rd_blk(32'h1000_0000);
    chk("valid_after_read", {31'd0, blk_valid_o}, 32'd0);
    chk("free_after_read", {30'd0, free_banks_o}, {30'd0, FREE_ALL});
    chk("ovf_clean", {31'd0, ovf_o}, 32'd0);

    // Underflow: ignored read, data holds, rlast drops
    cyc(1'b0, 1'b0, '0, 1'b1);
    chk("udf_set", {31'd0, udf_o}, 32'd1);
    chk("udf_rdata_hold", rdata_o, 32'h1000_001F);
    chk("udf_rlast", {31'd0, rlast_o}, 32'd0);

    // Clear with a concurrent write, then a fresh block from word 0
    for (int i = 0; i < 10; i++) cyc(1'b0, 1'b1, 32'h2000_0000 + 32'(i), 1'b0);
    cyc(1'b1, 1'b1, 32'hFFFF_FFFF, 1'b1);
    chk("clr_flags", {30'd0, ovf_o, udf_o}, 32'd0);
    chk("clr_valid", {31'd0, blk_valid_o}, 32'd0);
    chk("clr_free", {30'd0, free_banks_o}, {30'd0, FREE_ALL});
    chk("clr_rdata_hold", rdata_o, 32'h1000_001F);
    wr_blk(32'h3000_0000);
    rd_blk(32'h3000_0000);

`ifdef AIDC_LITE_BLK_BUF_PINGPONG_EN
    // Ping-pong: fill A, then fill B while reading A
    wr_blk(32'hA000_0000);
    wr_rd_blk(32'hB000_0000, 32'hA000_0000);
    chk("pp_no_ovf", {31'd0, ovf_o}, 32'd0);
    chk("pp_valid_b", {31'd0, blk_valid_o}, 32'd1);
    chk("pp_free", {30'd0, free_banks_o}, 32'd1);
    rd_blk(32'hB000_0000);
    chk("pp_free_empty", {30'd0, free_banks_o}, 32'd2);

    // Overflow with both banks full
    wr_blk(32'hC000_0000);
    wr_blk(32'hD000_0000);
    chk("ovf_free0", {30'd0, free_banks_o}, 32'd0);
    cyc(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0);
    chk("ovf_set", {31'd0, ovf_o}, 32'd1);
    rd_blk(32'hC000_0000);
    chk("valid_other_full", {31'd0, blk_valid_o}, 32'd1);
    rd_blk(32'hD000_0000);
`else
    // Overflow after one block in single-bank mode
    wr_blk(32'hC000_0000);
    chk("ovf_free0", {30'd0, free_banks_o}, 32'd0);
    cyc(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0);
    chk("ovf_set", {31'd0, ovf_o}, 32'd1);
    rd_blk(32'hC000_0000);
`endif
    chk("ovf_sticky", {31'd0, ovf_o}, 32'd1);
    chk("valid_drained", {31'd0, blk_valid_o}, 32'd0);

    // Asynchronous reset in the middle of a read burst
    wr_blk(32'hE000_0000);
    for (int i = 0; i < 17; i++) begin
      exp_q.push_back({1'b0, 32'hE000_0000 + 32'(i)});
      cyc(1'b0, 1'b0, '0, 1'b1);
    end
    rden_i = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_rdata", rdata_o, 32'd0);
    chk("arst_flags", {28'd0, blk_valid_o, rlast_o, ovf_o, udf_o}, 32'd0);
    rden_i = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #2;
    chk("arst_free", {30'd0, free_banks_o}, {30'd0, FREE_ALL});
    wr_blk(32'hF000_0000);
    rd_blk(32'hF000_0000);

    repeat (2) @(posedge clk);
    #2;
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/aidc_lite_blk_buf.md
# aidc_lite_blk_buf

Block staging buffer that sits directly downstream of the AIDC-Lite compression engine's AHB read path. It captures the 32 words (128B) of each source block written by the engine's `buf_wren`/`buf_wdata` strobe, then presents the complete block to the compressor core as an in-order 32-word read stream. Two banks (ping-pong) let the engine fetch block N+1 while the compressor consumes block N.

## Interface
- `WORDS_PER_BLK`, 32: words per block; must be a power of two, 2..64.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `clear_i`  in  1  synchronous flush pulse, driven on engine start.
- `wren_i`  in  1  write strobe, from engine `buf_wren_o`.
- `wdata_i`  in  32  write data, from engine `buf_wdata_o`.
- `blk_valid_o`  out  1  a complete block is readable (level).
- `rden_i`  in  1  compressor read strobe, one word per cycle.
- `rdata_o`  out  32  read data, registered.
- `rlast_o`  out  1  qualifies `rdata_o` as the final word of the block.
- `free_banks_o`  out  2  number of banks able to accept writes (0..2).
- `ovf_o`  out  1  sticky: a write was dropped.
- `udf_o`  out  1  sticky: a read was issued with `blk_valid_o` low.

## Operation
- Storage: 2 banks × `WORDS_PER_BLK` × 32b, plus per-bank `full` flag, `wr_bank`, `rd_bank`, `wr_ptr`, `rd_ptr` (log2(`WORDS_PER_BLK`) bits each).
- Write: when `wren_i` is high and `full[wr_bank]`=0, word goes to `bank[wr_bank][wr_ptr]` and `wr_ptr` increments. On the last index, `wr_ptr` wraps to 0, `full[wr_bank]` sets and `wr_bank` toggles.
- Write into a full bank: data is dropped, pointers are unchanged, and `ovf_o` sets.
- Read: when `rden_i` is high and `full[rd_bank]`=1, `rdata_o` loads `bank[rd_bank][rd_ptr]` and `rd_ptr` increments. On the last index, `rd_ptr` wraps to 0, `full[rd_bank]` clears, `rd_bank` toggles and `rlast_o` loads 1. Otherwise `rlast_o` loads 0.
- Read with `blk_valid_o`=0: ignored, `rdata_o` holds, `rlast_o` loads 0, and `udf_o` sets.
- `blk_valid_o` = `full[rd_bank]`, decoded combinationally from registers.
- `free_banks_o` = count of clear `full` flags.
- Simultaneous completion of a write to one bank and a read from the other: both take effect on the same edge.
- Same-bank read/write overlap cannot occur (a bank is never both filling and full).
- `clear_i`: zeroes pointers, bank selects, `full` flags, `rlast_o`, `ovf_o` and `udf_o`. `rdata_o` holds. `clear_i` has priority over `wren_i`/`rden_i` in the same cycle; those strobes are discarded without setting the error flags.
- Reset: all registers and outputs are 0. `free_banks_o` is 2 (1 without ping-pong). Reset mid-block discards partial data.

## Timing
- Write-to-valid latency: `blk_valid_o` rises the cycle after the edge capturing the last word.
- Read latency: 1 cycle. `rden_i` sampled at edge k gives `rdata_o`/`rlast_o` valid after edge k and held until the next accepted read.
- Back-to-back reads: `rden_i` may be held high for 32 consecutive cycles. `blk_valid_o` falls after the edge accepting the last read, or stays high if the other bank is full.
- Full throughput: a write every cycle and a read every cycle are sustained concurrently.
- No internal state machine beyond the bank/pointer registers; the engine's state sequence (RD1 data → RD2 data → compress) is transparent.

## Configuration
- `AIDC_LITE_BLK_BUF_PINGPONG_EN` defined: two banks as described; `free_banks_o` ranges 0..2.
- `AIDC_LITE_BLK_BUF_PINGPONG_EN` undefined:
  - only bank 0 exists; `wr_bank`/`rd_bank` are constant 0.
  - writes arriving while bank 0 is full are dropped with `ovf_o`.
  - `free_banks_o` is 0 or 1, and the MSB is tied to 0.

## Test plan
- Reset, then write words 0x1000_0000..0x1000_001F, one per cycle → `blk_valid_o`=1 the cycle after the 32nd write. Then hold `rden_i` for 32 cycles → `rdata_o` returns the same sequence with 1-cycle latency, `rlast_o`=1 only with 0x1000_001F, and `blk_valid_o`=0 afterwards.
- Ping-pong: write block A (0xA…), then block B (0xB…) while reading A concurrently → no `ovf_o`, A then B read in order, `free_banks_o` never exceeds 2.
- Overflow: fill both banks, then write 0xDEAD_BEEF → `ovf_o`=1, later reads never return 0xDEAD_BEEF. With the macro undefined, the same overflow occurs after one block.
- Underflow: `rden_i`=1 with `blk_valid_o`=0 → `udf_o`=1 and `rdata_o` unchanged.
- Clear: write 10 words, then assert `clear_i` together with `wren_i` → pointers are 0, `ovf_o`/`udf_o` are 0, and a fresh 32-word block reads back correctly starting at word 0.
- Asynchronous reset asserted mid-read (word 17) → all outputs 0 immediately, `free_banks_o`=2 after release.
